// File: rtl/ssp_rx_deserializer_if.sv
// ssp_rx_deserializer_if
//   Groups the SSP receive front-end signals.
//   master : drives the serial pins, enable and FIFO-full flag (the environment)
//   slave  : the deserializer, drives rxdata/rx_wr/rx_overrun/rx_busy
//   sse        SSP enable
//   sspclkin   external serial clock (asynchronous)
//   sspfssin   frame-sync, active high
//   ssprxd     serial receive data
//   flag_full  RxFIFO full
//   rxdata     assembled word to RxFIFO
//   rx_wr      one-cycle RxFIFO write strobe
//   rx_overrun one-cycle pulse, word dropped because FIFO full
//   rx_busy    frame in progress
interface ssp_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sse;
    logic                  sspclkin;
    logic                  sspfssin;
    logic                  ssprxd;
    logic                  flag_full;
    logic [DATA_WIDTH-1:0] rxdata;
    logic                  rx_wr;
    logic                  rx_overrun;
    logic                  rx_busy;

    modport master (
        output sse, sspclkin, sspfssin, ssprxd, flag_full,
        input  rxdata, rx_wr, rx_overrun, rx_busy
    );

    modport slave (
        input  sse, sspclkin, sspfssin, ssprxd, flag_full,
        output rxdata, rx_wr, rx_overrun, rx_busy
    );
endinterface

// File: rtl/ssp_rx_deserializer.sv
// ssp_rx_deserializer
//   Receive-side serial front end. Synchronises the external serial clock,
//   frame-sync and data onto pclk, shifts MSB-first frames into a
//   DATA_WIDTH-bit word and pushes each complete word into the RxFIFO.
//   A word completing while the FIFO is full is dropped with rx_overrun.
//   pclk   system clock, rising edge
//   clr_b  asynchronous active-low reset
//   bus    ssp_rx_if slave modport (pins, enable, FIFO handshake, status)
module ssp_rx_deserializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic    pclk,
    input  logic    clr_b,
    ssp_rx_if.slave bus
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronisers: all three lines see the same number of stages so the
    // data and frame-sync stay aligned with the clock they were launched on.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] fss_sync;
    logic [SYNC_STAGES-1:0] rxd_sync;
    logic                   s_sck_d;

    logic s_sck;
    logic s_fss;
    logic s_rxd;
    logic sck_rise;

    assign s_sck    = sck_sync[SYNC_STAGES-1];
    assign s_fss    = fss_sync[SYNC_STAGES-1];
    assign s_rxd    = rxd_sync[SYNC_STAGES-1];
    assign sck_rise = s_sck & ~s_sck_d;

    // Synchronisers ignore sse so edge detection is valid the moment the
    // block is re-enabled.
    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            sck_sync <= '0;
            fss_sync <= '0;
            rxd_sync <= '0;
            s_sck_d  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sspclkin};
            fss_sync <= {fss_sync[SYNC_STAGES-2:0], bus.sspfssin};
            rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], bus.ssprxd};
            s_sck_d  <= s_sck;
        end
    end

    state_t                state, state_n;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  push_pend, push_pend_n;

    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            push_pend <= push_pend_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        push_pend_n = 1'b0;
        if (!bus.sse) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
        end else if (sck_rise) begin
            case (state)
                IDLE: begin
                    // Frame-sync bit period carries no data; only arms the shift.
                    if (s_fss) begin
                        state_n   = SHIFT;
                        bit_cnt_n = '0;
                    end
                end
                SHIFT: begin
                    shreg_n = {shreg[DATA_WIDTH-2:0], s_rxd};
                    if (bit_cnt == LAST_BIT) begin
                        push_pend_n = 1'b1;
                        bit_cnt_n   = '0;
                        // Frame-sync on the LSB chains straight into the next frame.
                        if (!s_fss) state_n = IDLE;
                    end else begin
                        // Frame-sync before the LSB is ignored; no restart.
                        bit_cnt_n = bit_cnt + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Push stage: one cycle after the last bit lands in shreg.
    logic [DATA_WIDTH-1:0] rxdata_q;
    logic                  rx_wr_q;
    logic                  rx_overrun_q;

    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            rxdata_q     <= '0;
            rx_wr_q      <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_wr_q      <= 1'b0;
            rx_overrun_q <= 1'b0;
            if (push_pend && bus.sse) begin
                if (!bus.flag_full) begin
                    rxdata_q <= shreg;
                    rx_wr_q  <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rxdata     = rxdata_q;
    assign bus.rx_wr      = rx_wr_q;
    assign bus.rx_overrun = rx_overrun_q;
    assign bus.rx_busy    = (state == SHIFT);

endmodule

// File: doc/ssp_rx_deserializer.md
Name: ssp_rx_deserializer

Overview:
Receive-side serial front end of the SSP. It samples the external serial clock, frame-sync and data lines on pclk and assembles MSB-first frames into DATA_WIDTH-bit words. Each complete word is pushed into the downstream receive FIFO as a one-cycle write strobe with the data on rxdata. When the FIFO is full, the word is dropped and an overrun is flagged.

Parameters:
DATA_WIDTH, 8, bits per frame and width of rxdata
SYNC_STAGES, 2, flip-flop stages on each of sspclkin/sspfssin/ssprxd (minimum 2)

Ports:
pclk  input  1  system clock; all logic on rising edge
clr_b  input  1  asynchronous active-low reset
sse  input  1  SSP enable; 0 holds block idle
sspclkin  input  1  external serial clock (asynchronous to pclk)
sspfssin  input  1  frame-sync pulse, active high
ssprxd  input  1  serial receive data
flag_full  input  1  downstream RxFIFO full flag
rxdata  output  DATA_WIDTH  assembled word to RxFIFO data input
rx_wr  output  1  one-cycle write strobe to RxFIFO write enable
rx_overrun  output  1  one-cycle pulse: completed word dropped because FIFO full
rx_busy  output  1  high while a frame is being shifted in

Behaviour:
- Interface (decided): single clock pclk; reset clr_b is asynchronous, active-low.
- Reset values: rxdata=0, rx_wr=0, rx_overrun=0, rx_busy=0, state=IDLE, bit_cnt=0, shift register=0, synchroniser flops=0.
- Synchronisation:
  - sspclkin, sspfssin and ssprxd each pass through SYNC_STAGES flops, giving s_sck, s_fss and s_rxd, all aligned.
  - s_sck_d is s_sck delayed one cycle. sck_rise = s_sck & ~s_sck_d.
  - Input constraint: each sspclkin level lasts at least 2 pclk cycles.
- FSM states: IDLE, SHIFT.
  - IDLE, on sck_rise with s_fss=1: go to SHIFT, bit_cnt=0, rx_busy=1. The frame-sync bit period carries no data.
  - IDLE, on sck_rise with s_fss=0: no action.
  - SHIFT, on each sck_rise: shreg <= {shreg[DATA_WIDTH-2:0], s_rxd} (MSB first), then bit_cnt increments.
  - SHIFT, on the sck_rise where bit_cnt==DATA_WIDTH-1: the word is complete. Set push_pend=1.
    - If s_fss=1 on that same edge (continuous transfer), stay in SHIFT with bit_cnt=0.
    - Otherwise go to IDLE with rx_busy=0.
  - s_fss=1 during SHIFT when bit_cnt<DATA_WIDTH-1 is ignored. It does not restart the frame.
- Push, in the cycle after push_pend is set:
  - If flag_full=0: rxdata <= completed word and rx_wr=1 for exactly one cycle.
  - If flag_full=1: rx_overrun=1 for one cycle, rx_wr stays 0, and rxdata is not updated (word discarded).
  - Latency: rx_wr is asserted 1 pclk after the pclk edge that captured the last bit. That is SYNC_STAGES+2 pclk after the sspclkin rising edge at the pin.
  - rxdata holds its value until the next successful push.
  - At most one push per frame. Back-to-back frames are at least DATA_WIDTH sck periods apart, so pushes never overlap.
- sse=0: synchronous abort. State goes to IDLE, bit_cnt=0, rx_busy=0, push_pend=0, and no rx_wr or rx_overrun is issued. rxdata is held. Synchronisers keep running.
- Reset mid-frame: all state clears immediately. The partial word is lost and no strobe is issued. The next frame requires a fresh frame-sync.
- bit_cnt width is clog2(DATA_WIDTH). The counter never exceeds DATA_WIDTH-1 and never wraps outside SHIFT.

Test Plan:
1. Reset, sse=1, flag_full=0, sck period 8 pclk. Send one fss bit, then 0xA2 MSB-first -> exactly one rx_wr pulse with rxdata=0xA2; rx_busy falls when the last bit is captured; rx_overrun stays 0.
2. Continuous frames 0xC3 then 0xFF, with fss high during the LSB of the first frame -> two rx_wr pulses 8 sck periods apart, rxdata=0xC3 then 0xFF; no IDLE gap (rx_busy stays 1).
3. flag_full=1 while frame 0xCC completes -> rx_overrun pulse for one cycle, no rx_wr, rxdata keeps its previous value 0xFF.
4. clr_b pulsed low after 4 bits of 0xBB, then a full frame 0x12 -> no strobe for the partial frame; rx_wr with rxdata=0x12.
5. sse=0 mid-frame after 3 bits, sse=1, then frame 0x37 -> no strobe for the aborted frame; rxdata=0x37 on the next rx_wr.
6. fss asserted at bit 3 of frame 0x5A (not at the LSB) -> frame not restarted; rxdata=0x5A; block returns to IDLE afterwards.
